// File: rtl/fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkt_reader
// Brief    : Pops header-framed packets from an FWFT FIFO onto a registered
//            valid/ready stream with sop/eop markers and a packet counter.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_pkt_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  pkt_done,
    output logic [15:0]           pkt_count
);

    localparam logic [0:0] S_HDR  = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [LEN_WIDTH-1:0]  w_remaining_nxt;
    logic [LEN_WIDTH-1:0]  w_len;

    logic                  w_load;
    logic                  w_pop;
    logic                  w_sop_nxt;
    logic                  w_eop_nxt;
    logic                  w_accept_eop;

    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic                  r_m_sop;
    logic                  r_m_eop;
    logic                  r_pkt_done;
    logic [15:0]           r_pkt_count;

    assign w_len = fifo_dout[LEN_WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HDR;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    // Next-state logic: the FSM only advances on a pop
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        if (w_pop) begin
            case (r_state)
                S_HDR: begin
                    if (w_len != '0) begin
                        w_state_nxt     = S_BODY;
                        w_remaining_nxt = w_len;
                    end
                end
                S_BODY: begin
                    w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
                    if (r_remaining == LEN_WIDTH'(1)) begin
                        w_state_nxt = S_HDR;
                    end
                end
                default: w_state_nxt = S_HDR;
            endcase
        end
    end

    // Output logic: en gates only the start of a packet, never its body
    always_comb begin
        w_load    = ~r_m_valid | m_ready;
        w_pop     = ~fifo_empty & w_load & ((r_state == S_BODY) | en);
        w_sop_nxt = (r_state == S_HDR);
        w_eop_nxt = (r_state == S_HDR) ? (w_len == '0)
                                       : (r_remaining == LEN_WIDTH'(1));
    end

    assign w_accept_eop = r_m_valid & m_ready & r_m_eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_sop     <= 1'b0;
            r_m_eop     <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            if (w_load) begin
                r_m_valid <= w_pop;
                if (w_pop) begin
                    r_m_data <= fifo_dout;
                    r_m_sop  <= w_sop_nxt;
                    r_m_eop  <= w_eop_nxt;
                end
            end
            r_pkt_done <= w_accept_eop;
            if (w_accept_eop) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    // Keep the FIFO untouched while reset is held
    assign fifo_rd_en = w_pop & rst_n;
    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign m_sop      = r_m_sop;
    assign m_eop      = r_m_eop;
    assign pkt_done   = r_pkt_done;
    assign pkt_count  = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pkt_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fifo_pkt_reader
// Brief    : Scoreboard bench for fifo_pkt_reader with an FWFT FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_pkt_reader;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sop;
    logic        m_eop;
    logic        pkt_done;
    logic [15:0] pkt_count;

    logic [7:0]  fq[$];
    beat_t       eq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_cnt = 0;
    logic        exp_done = 1'b0;
    logic        pop_flag = 1'b0;

    fifo_pkt_reader #(.DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .pkt_done   (pkt_done),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    task automatic push(input logic [7:0] d, input logic sop, input logic eop);
        beat_t b;
        b.d = d; b.sop = sop; b.eop = eop;
        fq.push_back(d);
        eq.push_back(b);
        upd();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while ((eq.size() != 0 || fq.size() != 0) && c < maxc) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= maxc) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats pending, expected 0", eq.size());
        end
        step(3);
    endtask

    // FIFO model: pop what the DUT saw requested at the previous negedge
    always @(posedge clk) begin
        if (pop_flag) begin
            #1;
            if (fq.size() != 0) void'(fq.pop_front());
            upd();
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            exp_done = 1'b0;
        end else begin
            if (exp_done || pkt_done) chk("pkt_done", 32'(pkt_done), 32'(exp_done));
            if (exp_done) model_cnt++;
            exp_done = 1'b0;
            if (m_valid && m_ready) begin
                if (eq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_data);
                end else begin
                    b = eq.pop_front();
                    chk("beat_data", 32'(m_data), 32'(b.d));
                    chk("beat_sop",  32'(m_sop),  32'(b.sop));
                    chk("beat_eop",  32'(m_eop),  32'(b.eop));
                    exp_done = b.eop;
                end
            end
        end
        pop_flag = fifo_rd_en;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sd;
        logic       ss, se;
        int         c;

        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1;
        upd();
        push(8'h50, 1'b1, 1'b1);
        @(negedge clk);
        chk("rst_m_valid",   32'(m_valid),    32'd0);
        chk("rst_m_data",    32'(m_data),     32'd0);
        chk("rst_m_sop",     32'(m_sop),      32'd0);
        chk("rst_m_eop",     32'(m_eop),      32'd0);
        chk("rst_pkt_done",  32'(pkt_done),   32'd0);
        chk("rst_pkt_count", 32'(pkt_count),  32'd0);
        chk("rst_rd_en",     32'(fifo_rd_en), 32'd0);
        step(2);
        rst_n = 1'b1;
        drain(50);
        chk("cnt_after_init", 32'(pkt_count), 32'd1);

        // 1: hdr len=2, A, B back to back
        push(8'h12, 1'b1, 1'b0);
        push(8'hA1, 1'b0, 1'b0);
        push(8'hB2, 1'b0, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_back_to_back", 32'(m_valid), 32'd1);
        end
        drain(50);
        chk("t1_cnt", 32'(pkt_count), 32'd2);

        // 2: header-only packet followed by a normal packet
        push(8'h20, 1'b1, 1'b1);
        push(8'h31, 1'b1, 1'b0);
        push(8'hC1, 1'b0, 1'b1);
        drain(50);
        chk("t2_cnt", 32'(pkt_count), 32'd4);

        // 3: stall mid-body for 5 cycles
        push(8'h44, 1'b1, 1'b0);
        push(8'hD1, 1'b0, 1'b0);
        push(8'hD2, 1'b0, 1'b0);
        push(8'hD3, 1'b0, 1'b0);
        push(8'hD4, 1'b0, 1'b1);
        step(2);
        m_ready = 1'b0;
        @(negedge clk);
        sd = m_data; ss = m_sop; se = m_eop;
        chk("t3_stall_data0", 32'(sd), 32'hD1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_valid", 32'(m_valid),    32'd1);
            chk("t3_stall_data",  32'(m_data),     32'(sd));
            chk("t3_stall_sop",   32'(m_sop),      32'(ss));
            chk("t3_stall_eop",   32'(m_eop),      32'(se));
            chk("t3_stall_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        drain(50);
        chk("t3_cnt", 32'(pkt_count), 32'd5);

        // 4: en dropped right after the header pop
        push(8'h53, 1'b1, 1'b0);
        push(8'hE1, 1'b0, 1'b0);
        push(8'hE2, 1'b0, 1'b0);
        push(8'hE3, 1'b0, 1'b1);
        push(8'h60, 1'b1, 1'b1);
        c = 0;
        @(negedge clk);
        while (!fifo_rd_en && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("t4_hdr_pop_seen", 32'(fifo_rd_en), 32'd1);
        @(posedge clk); #1;
        en = 1'b0;
        step(10);
        @(negedge clk);
        chk("t4_fifo_left",  32'(fq.size()),   32'd1);
        chk("t4_rd_en_held", 32'(fifo_rd_en),  32'd0);
        chk("t4_idle",       32'(m_valid),     32'd0);
        chk("t4_cnt_mid",    32'(pkt_count),   32'd6);
        @(posedge clk); #1;
        en = 1'b1;
        drain(50);
        chk("t4_cnt", 32'(pkt_count), 32'd7);

        // 5: FIFO runs dry after first payload word
        push(8'h73, 1'b1, 1'b0);
        push(8'hF1, 1'b0, 1'b0);
        step(5);
        @(negedge clk);
        chk("t5_bubble", 32'(m_valid),    32'd0);
        chk("t5_rd_en",  32'(fifo_rd_en), 32'd0);
        @(posedge clk); #1;
        push(8'hF2, 1'b0, 1'b0);
        push(8'hF3, 1'b0, 1'b1);
        drain(50);
        chk("t5_cnt", 32'(pkt_count), 32'd8);

        // 6: async reset mid-body, then a fresh header
        push(8'h83, 1'b1, 1'b0);
        push(8'h81, 1'b0, 1'b0);
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(m_valid),   32'd0);
        chk("t6_data",  32'(m_data),    32'd0);
        chk("t6_sop",   32'(m_sop),     32'd0);
        chk("t6_eop",   32'(m_eop),     32'd0);
        chk("t6_cnt0",  32'(pkt_count), 32'd0);
        fq.delete();
        eq.delete();
        model_cnt = 0;
        upd();
        push(8'h91, 1'b1, 1'b0);
        push(8'h99, 1'b0, 1'b1);
        #1;
        chk("t6_rd_en_in_rst", 32'(fifo_rd_en), 32'd0);
        step(2);
        rst_n = 1'b1;
        drain(50);
        chk("t6_cnt", 32'(pkt_count), 32'd1);

        // Counter wrap: 65534 more header-only packets reach 0xFFFF, one more wraps
        for (int i = 0; i < 65534; i++) push(8'h00, 1'b1, 1'b1);
        drain(70000);
        chk("wrap_ffff",  32'(pkt_count), 32'hFFFF);
        chk("wrap_model", 32'(pkt_count), 32'(model_cnt & 16'hFFFF));
        push(8'h00, 1'b1, 1'b1);
        drain(50);
        chk("wrap_zero",  32'(pkt_count), 32'd0);
        chk("wrap_model2", 32'(pkt_count), 32'(model_cnt & 16'hFFFF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
